poly_msub: RTL

POLY_MSUB -- requirements
Module: poly_msub

---
 rtl/poly_pkg.sv | 14 +
 rtl/mod_mul_q.sv | 29 ++
 rtl/poly_msub.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// Shared types and default sizing for the polynomial
// multiply-subtract engine.
package poly_pkg;
  localparam int CW_DEF = 13;
  localparam int unsigned Q_DEF = 4591;
  localparam int AW_DEF = 11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;
endpackage

// File: rtl/mod_mul_q.sv
// Two-stage pipelined modular multiplier, p = a*b mod Q.
// Stage 1 forms the full product, stage 2 reduces it.
module mod_mul_q
  import poly_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic [CW-1:0] p
);
  localparam logic [2*CW-1:0] QW = (2*CW)'(Q);

  logic [2*CW-1:0] prodR;

  // product register, then reduction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prodR <= '0;
      p     <= '0;
    end else begin
      prodR <= {{CW{1'b0}}, a} * {{CW{1'b0}}, b};
      p     <= CW'(prodR % QW);
    end
  end
endmodule

// File: rtl/poly_msub.sv
// R[i] = N[i] - c*D[i-s] mod Q, streamed from degN down to 0.
// POLY_MSUB_SCALE_EN enables the c multiplier; otherwise R = N - D.
module poly_msub
  import poly_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int unsigned Q = Q_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] degN,
  input  logic [AW-1:0] degD,
  input  logic [CW-1:0] c,
  output logic [AW-1:0] addrN,
  output logic [AW-1:0] addrD,
  input  logic [CW-1:0] dataN,
  input  logic [CW-1:0] dataD,
  output logic [AW-1:0] wr_addr,
  output logic [CW-1:0] wr_data,
  output logic          we,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] deg,
  output logic          zero,
  output logic          err
);
  localparam logic [CW-1:0] QC = CW'(Q);

  state_t state, nextState;

  logic          accept, bad, lastWr, found;
  logic [AW-1:0] iCnt, sR;
  logic          vldA, zA, vldB, vldC;
  logic [AW-1:0] idxA, idxB, idxC;
  logic [CW-1:0] nB, nC, dOp, pC, fix;
  logic [CW:0]   diff;

  assign accept = (state == IDLE) && start;
  assign bad    = degD > degN;
  assign addrN  = iCnt;
  assign addrD  = (iCnt >= sR) ? iCnt - sR : '0;
  assign lastWr = vldC && (idxC == '0);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // next state, busy and done
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nextState = bad ? DRAIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (iCnt == '0) nextState = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (err || lastWr) nextState = FIN;
      end
      FIN: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // command latch, index counter and result degree tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iCnt  <= '0;
      sR    <= '0;
      err   <= 1'b0;
      found <= 1'b0;
      deg   <= '0;
      zero  <= 1'b0;
    end else begin
      if (accept) begin
        err   <= bad;
        deg   <= bad ? degN : '0;
        zero  <= 1'b0;
        found <= 1'b0;
        sR    <= bad ? '0 : degN - degD;
        if (!bad) iCnt <= degN;
      end else if (state == RUN && iCnt != '0) begin
        iCnt <= iCnt - 1'b1;
      end
      if (we && !found && wr_data != '0) begin
        found <= 1'b1;
        deg   <= wr_addr;
      end
      if (state == DRAIN && lastWr)
        zero <= !found && (wr_data == '0);
    end
  end

  // index/valid pipeline aligned with read data and product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldA <= 1'b0;
      zA   <= 1'b0;
      idxA <= '0;
      vldB <= 1'b0;
      idxB <= '0;
      nB   <= '0;
      vldC <= 1'b0;
      idxC <= '0;
      nC   <= '0;
    end else begin
      vldA <= state == RUN;
      zA   <= iCnt < sR;
      idxA <= iCnt;
      vldB <= vldA;
      idxB <= idxA;
      nB   <= dataN;
      vldC <= vldB;
      idxC <= idxB;
      nC   <= nB;
    end
  end

  assign dOp = zA ? '0 : dataD;

`ifdef POLY_MSUB_SCALE_EN
  logic [CW-1:0] cR;

  // scalar held for the whole run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cR <= '0;
    else if (accept) cR <= c;
  end

  mod_mul_q #(
    .CW(CW),
    .Q (Q)
  ) uMul (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (cR),
    .b    (dOp),
    .p    (pC)
  );
`else
  logic [CW-1:0] dB;
  logic          unusedC;

  assign unusedC = ^c;

  // two-stage delay standing in for the multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dB <= '0;
      pC <= '0;
    end else begin
      dB <= dOp;
      pC <= dB;
    end
  end
`endif

  assign diff    = {1'b0, nC} - {1'b0, pC};
  assign fix     = diff[CW-1:0] + QC;
  assign wr_data = diff[CW] ? fix : diff[CW-1:0];
  assign we      = vldC;
  assign wr_addr = idxC;
endmodule
